// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with a two-flop input synchronizer, an
//            oversampling tick generator and a four-state framing FSM.
//            Delivers each correctly framed byte with a one-cycle rx_valid
//            pulse and flags a low stop bit with a one-cycle frame_err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  // Clocks per oversample tick; counter width kept at least one bit.
  localparam int DIV = CLK_FREQ / (BAUD * OVS);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [3:0]    OS_HALF   = 4'(OVS / 2 - 1);
  localparam logic [3:0]    OS_LAST   = 4'(OVS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic            rx_meta, rx_s;
  logic [TW-1:0]   tick_cnt, tick_cnt_n;
  logic            tick;
  logic [3:0]      os_cnt, os_cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic [7:0]      rx_data_n;
  logic            rx_valid_n, frame_err_n;

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);
  assign busy = (state != IDLE);

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      os_cnt    <= 4'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      os_cnt    <= os_cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
    end
  end

  // Next-state logic: sample at mid start bit, then every OVS ticks.
  always_comb begin
    state_n     = state;
    os_cnt_n    = os_cnt;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    tick_cnt_n  = tick ? '0 : tick_cnt + TW'(1);

    case (state)
      IDLE: begin
        if (!rx_s) begin
          // Start edge: realign the tick phase to the edge.
          state_n    = START;
          os_cnt_n   = 4'd0;
          tick_cnt_n = '0;
        end
      end

      START: begin
        if (tick) begin
          if (os_cnt == OS_HALF) begin
            os_cnt_n = 4'd0;
            if (!rx_s) begin
              state_n   = DATA;
              bit_idx_n = 3'd0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state_n = IDLE;
            end
          end else begin
            os_cnt_n = os_cnt + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            os_cnt_n         = 4'd0;
            shreg_n[bit_idx] = rx_s;
            if (bit_idx == 3'd7) begin
              state_n = STOP;
            end else begin
              bit_idx_n = bit_idx + 3'd1;
            end
          end else begin
            os_cnt_n = os_cnt + 4'd1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            // Leave at mid stop bit so a following start edge is not missed.
            os_cnt_n = 4'd0;
            state_n  = IDLE;
            if (rx_s) begin
              rx_data_n  = shreg;
              rx_valid_n = 1'b1;
            end else begin
              frame_err_n = 1'b1;
            end
          end else begin
            os_cnt_n = os_cnt + 4'd1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx. Runs the receiver at a
//            scaled-down clock (DIV = 10, 160 clocks per bit) and drives
//            hand-built 8N1 frames, comparing pulses and data against
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int OVS      = 16;
  localparam int BIT      = 160;   // CLK_FREQ / BAUD clocks per bit

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_both  = 0;
  logic [7:0] got_q[$];

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OVS      (OVS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      got_q.push_back(rx_data);
    end
    if (frame_err) n_ferr++;
    if (rx_valid && frame_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Transmit one 8N1 frame; stop_low_len > 0 drives that many clocks of the
  // stop bit low before returning high.
  task automatic send_frame(input logic [7:0] d, input int blen, input int stop_low_len);
    @(negedge clk) rx = 1'b0;
    clocks(blen);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      clocks(blen);
    end
    if (stop_low_len > 0) begin
      rx = 1'b0;
      clocks(stop_low_len);
      rx = 1'b1;
      clocks(blen - stop_low_len);
    end else begin
      rx = 1'b1;
      clocks(blen);
    end
  endtask

  // Bounded wait for the receiver to drop busy, plus a settle margin.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
    clocks(2 * BIT);
  endtask

  int v0, f0;

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    clocks(5);
    check("rst_data",  {24'd0, rx_data}, 32'h00);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    clocks(20);

    // Single good frame.
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, BIT, 0);
    wait_idle("a5_idle");
    check("a5_count", n_valid - v0, 1);
    check("a5_data",  {24'd0, rx_data}, 32'hA5);
    check("a5_ferr",  n_ferr - f0, 0);
    if (got_q.size() > 0) check("a5_pulse_data", {24'd0, got_q.pop_front()}, 32'hA5);

    // Stop bit low: frame error, data held; line stays low past the sample.
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h55, BIT, 100);
    wait_idle("ferr_idle");
    check("ferr_count",  n_ferr - f0, 1);
    check("ferr_valid",  n_valid - v0, 0);
    check("ferr_data",   {24'd0, rx_data}, 32'hA5);

    // Back-to-back frames, no idle gap.
    v0 = n_valid;
    send_frame(8'h00, BIT, 0);
    send_frame(8'hFF, BIT, 0);
    send_frame(8'h3C, BIT, 0);
    wait_idle("b2b_idle");
    check("b2b_count", n_valid - v0, 3);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] expb;
      expb = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h3C;
      if (got_q.size() > 0) check($sformatf("b2b_byte%0d", i), {24'd0, got_q.pop_front()}, {24'd0, expb});
      else check($sformatf("b2b_byte%0d_missing", i), 32'd1, 32'd0);
    end

    // Short low glitch, well under half a bit.
    v0 = n_valid; f0 = n_ferr;
    @(negedge clk) rx = 1'b0;
    clocks(20);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    clocks(30);
    rx = 1'b1;
    clocks(200);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_valid",   n_valid - v0, 0);
    check("glitch_ferr",    n_ferr - f0, 0);
    check("glitch_data",    {24'd0, rx_data}, 32'h3C);

    // Reset during data bit 4 (rx high there and for the rest of 0xF5).
    v0 = n_valid; f0 = n_ferr;
    fork
      send_frame(8'hF5, BIT, 0);
      begin
        clocks(BIT * 5 + BIT / 2);
        rst_n = 1'b0;
        clocks(3);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
      end
    join
    wait_idle("midrst_idle");
    check("midrst_valid", n_valid - v0, 0);
    check("midrst_ferr",  n_ferr - f0, 0);
    check("midrst_data",  {24'd0, rx_data}, 32'h00);
    send_frame(8'h81, BIT, 0);
    wait_idle("r81_idle");
    check("r81_count", n_valid - v0, 1);
    check("r81_data",  {24'd0, rx_data}, 32'h81);
    got_q.delete();

    // Transmitter baud error of -3% and +3%.
    send_frame(8'h96, 155, 0);
    wait_idle("fast_idle");
    check("fast_data", {24'd0, rx_data}, 32'h96);
    send_frame(8'h00, BIT, 0);
    wait_idle("mid_idle");
    check("mid_data", {24'd0, rx_data}, 32'h00);
    send_frame(8'h96, 165, 0);
    wait_idle("slow_idle");
    check("slow_data", {24'd0, rx_data}, 32'h96);

    check("never_both", n_both, 0);
    check("ferr_total", n_ferr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
